apb_irq_ctrl: RTL and testbench

APB-mapped interrupt controller sitting directly downstream of the peripheral timers (`apb_psi_timer` `irq_o_timer[1:0]`) and other peripherals, and upstream of the RISC-V core's external-interrupt input. It latches per-source interrupt events, applies enable masking, and selects the lowest-numbered pending source. It presents that source to the core through a request/acknowledge handshake and holds off further requests until software signals end-of-interrupt.

---
 rtl/irq_ctrl_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/apb_irq_ctrl.sv | 157 +++++++++++++++
 tb/tb_apb_irq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the APB interrupt controller.
package irq_ctrl_pkg;

  // Width of an interrupt source id (up to 32 sources).
  localparam int IRQ_ID_W = 5;

  // Register select values, taken from PADDR[4:2].
  localparam logic [2:0] IRQ_PENDING = 3'd0;
  localparam logic [2:0] IRQ_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_TYPE    = 3'd2;
  localparam logic [2:0] IRQ_ACTIVE  = 3'd3;
  localparam logic [2:0] IRQ_EOI     = 3'd4;
  localparam logic [2:0] IRQ_SWSET   = 3'd5;

  // Request/acknowledge/end-of-interrupt handshake states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-numbered candidate wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]  cand_i,
  output logic                valid_o,
  output logic [IRQ_ID_W-1:0] id_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = |cand_i;
    id_o    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand_i[i]) begin
        id_o = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB-mapped interrupt controller: per-source edge/level latching, enable
// masking, lowest-id selection and a req/ack/EOI handshake to the core.
module apb_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_IRQ        = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_IRQ-1:0]        irq_src_i,
  output logic                      irq_req_o,
  output logic [IRQ_ID_W-1:0]       irq_id_o,
  input  logic                      irq_ack_i
);

  irq_state_e          state_q, state_d;
  logic [IRQ_ID_W-1:0] id_q, id_d;
  logic [NUM_IRQ-1:0]  enable_q, enable_d;
  logic [NUM_IRQ-1:0]  type_q, type_d;
  logic [NUM_IRQ-1:0]  src_q, src_d;
  logic [NUM_IRQ-1:0]  pend_edge_q, pend_edge_d;
  logic [NUM_IRQ-1:0]  swset_q, swset_d;

  logic                wr_en, rd_en, eoi_wr, ack_take;
  logic [2:0]          reg_sel;
  logic [NUM_IRQ-1:0]  wr_data, w1c_mask, swset_mask, id_mask, ack_clr;
  logic [NUM_IRQ-1:0]  pending, cand, pend_nxt, cand_nxt;
  logic                sel_valid, keep_req;
  logic [IRQ_ID_W-1:0] sel_id;
  logic                unused_bits;

  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign unused_bits = ^{PADDR, PWDATA};

  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign rd_en   = PSEL & PENABLE & ~PWRITE;
  assign reg_sel = PADDR[4:2];
  assign wr_data = PWDATA[NUM_IRQ-1:0];
  assign id_mask = NUM_IRQ'(1) << id_q;

  assign w1c_mask   = (wr_en && reg_sel == IRQ_PENDING) ? wr_data : '0;
  assign swset_mask = (wr_en && reg_sel == IRQ_SWSET) ? wr_data : '0;
  assign eoi_wr     = wr_en && reg_sel == IRQ_EOI;
  assign ack_take   = (state_q == REQ) && irq_ack_i;
  assign ack_clr    = ack_take ? (id_mask & type_q) : '0;

  // Edge sources use the latched flag; level sources follow the wire plus the
  // software-set latch, so their pending bit needs no extra cycle.
  assign pending = (pend_edge_q & type_q) | ((irq_src_i | swset_q) & ~type_q);
  assign cand    = pending & enable_q;

  // What the candidate vector will be after this edge, so a software write
  // that masks or clears the requested id retracts the request immediately.
  assign pend_nxt = (pend_edge_d & type_q) | ((irq_src_i | swset_d) & ~type_q);
  assign cand_nxt = pend_nxt & enable_d;
  assign keep_req = |(cand_nxt & id_mask);

  assign irq_req_o = (state_q == REQ);
  assign irq_id_o  = id_q;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .cand_i  (cand),
    .valid_o (sel_valid),
    .id_o    (sel_id)
  );

  // Register-file next state; on a same-cycle set and clear the set wins.
  always_comb begin
    enable_d = enable_q;
    type_d   = type_q;
    src_d    = irq_src_i;
    if (wr_en && reg_sel == IRQ_ENABLE) begin
      enable_d = wr_data;
    end
    if (wr_en && reg_sel == IRQ_TYPE) begin
      type_d = wr_data;
    end
    pend_edge_d = ((irq_src_i & ~src_q) | swset_mask
                   | (pend_edge_q & ~(w1c_mask | ack_clr))) & type_q;
    swset_d     = (swset_mask | (swset_q & ~w1c_mask)) & ~type_q;
  end

  // Handshake FSM: latch the winner, wait for ack, then wait for EOI.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = REQ;
          id_d    = sel_id;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = SERVE;
        end else if (!keep_req) begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (eoi_wr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational read mux; quiet outside a read access phase.
  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (reg_sel)
        IRQ_PENDING: PRDATA = 32'(pending);
        IRQ_ENABLE:  PRDATA = 32'(enable_q);
        IRQ_TYPE:    PRDATA = 32'(type_q);
        IRQ_ACTIVE:  PRDATA = {(state_q == SERVE), 26'd0, id_q};
        default:     PRDATA = '0;
      endcase
    end
  end

  // All state flops, cleared asynchronously.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q     <= IDLE;
      id_q        <= '0;
      enable_q    <= '0;
      type_q      <= '0;
      src_q       <= '0;
      pend_edge_q <= '0;
      swset_q     <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      enable_q    <= enable_d;
      type_q      <= type_d;
      src_q       <= src_d;
      pend_edge_q <= pend_edge_d;
      swset_q     <= swset_d;
    end
  end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed self-checking bench for apb_irq_ctrl.
module tb_apb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  irq_src = '0;
  logic        irq_req;
  logic [4:0]  irq_id;
  logic        irq_ack = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd;

  apb_irq_ctrl #(
    .APB_ADDR_WIDTH (12),
    .NUM_IRQ        (8)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .irq_src_i (irq_src),
    .irq_req_o (irq_req),
    .irq_id_o  (irq_id),
    .irq_ack_i (irq_ack)
  );

  always #5 HCLK = ~HCLK;

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  function automatic logic [11:0] regAddr(input logic [2:0] sel);
    return {7'd0, sel, 2'b00};
  endfunction

  // Drive the sources at a falling edge.
  task automatic applyStimulus(input logic [7:0] src);
    irq_src = src;
  endtask

  // Zero-wait APB write; takes effect at the rising edge ending the access phase.
  task automatic apbWrite(input logic [2:0] sel, input logic [31:0] data);
    PADDR = regAddr(sel); PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input logic [2:0] sel, output logic [31:0] data);
    PADDR = regAddr(sel); PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    #1 data = PRDATA;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    HRESET = 1'b1;
    tick();
    checkOutput("reset_req", irq_req, 0);
    checkOutput("reset_id", irq_id, 0);
    checkOutput("idle_prdata", PRDATA, 0);
    apbRead(IRQ_ENABLE, rd); checkOutput("reset_enable", rd, 0);

    // Edge path: sources 0,1,2,5 edge, 3,4 level
    apbWrite(IRQ_TYPE, 32'h27);
    apbWrite(IRQ_ENABLE, 32'h03);
    applyStimulus(8'h01); tick();
    applyStimulus(8'h00);
    checkOutput("edge_req_early", irq_req, 0);
    tick();
    checkOutput("edge_req", irq_req, 1);
    checkOutput("edge_id", irq_id, 0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checkOutput("edge_req_after_ack", irq_req, 0);
    apbRead(IRQ_PENDING, rd); checkOutput("edge_pending_cleared", rd, 0);
    apbRead(IRQ_ACTIVE, rd); checkOutput("edge_active_serve", rd, 32'h8000_0000);
    apbWrite(IRQ_EOI, 32'h0);
    apbRead(IRQ_ACTIVE, rd); checkOutput("edge_active_eoi", rd, 0);

    // Priority: 0 and 1 together, 0 first then 1
    applyStimulus(8'h03); tick();
    applyStimulus(8'h00); tick();
    checkOutput("prio_req0", irq_req, 1);
    checkOutput("prio_id0", irq_id, 0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checkOutput("prio_serve_req_a", irq_req, 0);
    tick();
    checkOutput("prio_serve_req_b", irq_req, 0);
    apbWrite(IRQ_EOI, 32'h0);
    checkOutput("prio_after_eoi", irq_req, 0);
    tick();
    checkOutput("prio_req1", irq_req, 1);
    checkOutput("prio_id1", irq_id, 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    apbWrite(IRQ_EOI, 32'h0);

    // Masking and retraction on source 2
    apbWrite(IRQ_ENABLE, 32'h00);
    applyStimulus(8'h04); tick();
    applyStimulus(8'h00); tick(); tick();
    checkOutput("mask_no_req", irq_req, 0);
    apbRead(IRQ_PENDING, rd); checkOutput("mask_pending", rd, 32'h04);
    apbWrite(IRQ_ENABLE, 32'h04);
    tick();
    checkOutput("unmask_req", irq_req, 1);
    checkOutput("unmask_id", irq_id, 2);
    apbWrite(IRQ_ENABLE, 32'h00);
    checkOutput("retract_req", irq_req, 0);
    tick();
    checkOutput("retract_stay_idle", irq_req, 0);
    apbRead(IRQ_PENDING, rd); checkOutput("retract_pending_kept", rd, 32'h04);
    apbWrite(IRQ_PENDING, 32'h04);
    apbRead(IRQ_PENDING, rd); checkOutput("w1c_pending", rd, 0);

    // Level source 3 held high
    apbWrite(IRQ_ENABLE, 32'h08);
    applyStimulus(8'h08); tick();
    checkOutput("level_req", irq_req, 1);
    checkOutput("level_id", irq_id, 3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checkOutput("level_serve_req", irq_req, 0);
    apbRead(IRQ_PENDING, rd); checkOutput("level_pending_kept", rd, 32'h08);
    apbWrite(IRQ_EOI, 32'h0);
    checkOutput("level_after_eoi", irq_req, 0);
    tick();
    checkOutput("level_rereq", irq_req, 1);
    checkOutput("level_reid", irq_id, 3);
    applyStimulus(8'h00); tick();
    checkOutput("level_drop_retract", irq_req, 0);

    // Software set on level source 4
    apbWrite(IRQ_ENABLE, 32'h10);
    apbWrite(IRQ_SWSET, 32'h10);
    checkOutput("swset_req_early", irq_req, 0);
    tick();
    checkOutput("swset_req", irq_req, 1);
    checkOutput("swset_id", irq_id, 4);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    apbRead(IRQ_PENDING, rd); checkOutput("swset_pending_kept", rd, 32'h10);
    apbWrite(IRQ_PENDING, 32'h10);
    apbWrite(IRQ_EOI, 32'h0);
    apbRead(IRQ_PENDING, rd); checkOutput("swset_cleared", rd, 0);
    checkOutput("swset_idle_req", irq_req, 0);

    // Edge on source 5 in the same cycle as its W1C: set wins
    apbWrite(IRQ_ENABLE, 32'h00);
    PADDR = regAddr(IRQ_PENDING); PWDATA = 32'h20; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    applyStimulus(8'h20);
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    applyStimulus(8'h00);
    apbRead(IRQ_PENDING, rd); checkOutput("collide_set_wins", rd, 32'h20);
    apbWrite(IRQ_PENDING, 32'h20);
    apbRead(IRQ_PENDING, rd); checkOutput("collide_w1c", rd, 0);

    // Reset while in SERVE
    apbWrite(IRQ_ENABLE, 32'h02);
    applyStimulus(8'h02); tick();
    applyStimulus(8'h00); tick();
    checkOutput("rst_pre_req", irq_req, 1);
    checkOutput("rst_pre_id", irq_id, 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    apbRead(IRQ_ACTIVE, rd); checkOutput("rst_pre_active", rd, 32'h8000_0001);
    apbWrite(IRQ_SWSET, 32'h08);
    #2 HRESET = 1'b0;
    #1;
    checkOutput("rst_async_req", irq_req, 0);
    checkOutput("rst_async_id", irq_id, 0);
    tick();
    HRESET = 1'b1;
    apbRead(IRQ_PENDING, rd); checkOutput("rst_pending", rd, 0);
    apbRead(IRQ_ENABLE, rd);  checkOutput("rst_enable", rd, 0);
    apbRead(IRQ_TYPE, rd);    checkOutput("rst_type", rd, 0);
    apbRead(IRQ_ACTIVE, rd);  checkOutput("rst_active", rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
